name_sequence_transmitter: RTL and testbench

- Character-stream source for the name sequence detector. On a start request it emits the fixed 8-character ASCII name "VIKHYATH", one byte per accepted transfer, under a valid/ready handshake.
- Supports repeating the name N+1 times with a programmable idle gap between repetitions, plus a synchronous abort.
- Drives the detector's 8-bit char input in loopback benches, and any byte-serial consumer in the design.

---
 rtl/name_seq_pkg.sv | 27 ++
 rtl/name_char_rom.sv | 18 +
 rtl/name_sequence_transmitter.sv | 134 +++++++++++++
 tb/tb_name_sequence_transmitter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/name_seq_pkg.sv
`default_nettype none
// ============================================================================
// name_seq_pkg : name ROM, widths and FSM encoding shared by transmitter/detector
// Revision     : 1.0
// ============================================================================
package name_seq_pkg;

    localparam int NAME_LEN = 8;
    localparam int IDX_W    = 3;
    localparam int REP_W    = 4;

    // Index 0 is the first character sent.
    localparam logic [7:0] NAME_ROM [NAME_LEN] = '{"V", "I", "K", "H", "Y", "A", "T", "H"};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(NAME_LEN - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/name_char_rom.sv
`default_nettype none
// ============================================================================
// name_char_rom : combinational character index -> ASCII byte lookup
// Revision      : 1.0
// ============================================================================
module name_char_rom
    import name_seq_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       char
);

    always_comb begin
        char = NAME_ROM[idx];
    end

endmodule
`default_nettype wire

// File: rtl/name_sequence_transmitter.sv
`default_nettype none
// ============================================================================
// name_sequence_transmitter : streams the name N+1 times over valid/ready
// Revision                  : 1.0
// ============================================================================
module name_sequence_transmitter
    import name_seq_pkg::*;
#(
    parameter int         GAP_CYCLES = 0,
    parameter logic [7:0] IDLE_CHAR  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic             abort,
    input  logic             char_ready,
    output logic [7:0]       char,
    output logic             char_valid,
    output logic             busy,
    output logic             done
);

    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [REP_W-1:0] rep, rep_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic             valid_nxt, busy_nxt, done_nxt;
    logic [7:0]       rom_char, char_nxt;

    // Lookup on the next index so the registered char lines up with valid.
    name_char_rom rom (
        .idx  (idx_nxt),
        .char (rom_char)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            rep        <= '0;
            gap_cnt    <= '0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            rep        <= rep_nxt;
            gap_cnt    <= gap_nxt;
            char       <= char_nxt;
            char_valid <= valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rep_nxt   = rep;
        gap_nxt   = gap_cnt;
        valid_nxt = char_valid;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SEND;
                    rep_nxt   = repeat_cnt;
                    idx_nxt   = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            ST_SEND: begin
                if (char_valid && char_ready) begin
                    if (!is_last_idx(idx)) begin
                        idx_nxt = idx + IDX_W'(1);
                    end else if (rep != '0) begin
                        rep_nxt = rep - REP_W'(1);
                        idx_nxt = '0;
                        if (GAP_CYCLES != 0) begin
                            state_nxt = ST_GAP;
                            valid_nxt = 1'b0;
                            gap_nxt   = GW'(GAP_CYCLES - 1);
                        end
                    end else begin
                        state_nxt = ST_DONE;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - GW'(1);
                end else begin
                    state_nxt = ST_SEND;
                    valid_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase

        // Abort overrides everything decided above.
        if (abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            rep_nxt   = '0;
            gap_nxt   = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end

        char_nxt = valid_nxt ? rom_char : IDLE_CHAR;
    end

endmodule
`default_nettype wire

// File: tb/tb_name_sequence_transmitter.sv
`default_nettype none
// ============================================================================
// tb_name_sequence_transmitter : directed table + corner sequences, GAP 0 and 2
// Revision                     : 1.0
// ============================================================================
module tb_name_sequence_transmitter;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b1;
    logic [3:0] rep   = 4'd0;

    logic [7:0] ch0, ch2;
    logic       vld0, busy0, done0, vld2, busy2, done2;

    int checks = 0;
    int errors = 0;

    logic [7:0] nm [8] = '{"V", "I", "K", "H", "Y", "A", "T", "H"};

    always #5 clk = ~clk;

    name_sequence_transmitter #(.GAP_CYCLES(0), .IDLE_CHAR(8'h00)) dut0 (
        .clk(clk), .rst(rst), .start(start), .repeat_cnt(rep), .abort(abort),
        .char_ready(ready), .char(ch0), .char_valid(vld0), .busy(busy0), .done(done0)
    );

    name_sequence_transmitter #(.GAP_CYCLES(2), .IDLE_CHAR(8'h00)) dut2 (
        .clk(clk), .rst(rst), .start(start), .repeat_cnt(rep), .abort(abort),
        .char_ready(ready), .char(ch2), .char_valid(vld2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic       st;
        logic [3:0] rc;
        logic       ab;
        logic       rd;
        logic [7:0] ch;
        logic       v;
        logic       b;
        logic       d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [3:0] rc, input logic ab,
                                input logic rd, input logic [7:0] ch, input logic v,
                                input logic b, input logic d);
        vec_t r;
        r.st = st; r.rc = rc; r.ab = ab; r.rd = rd;
        r.ch = ch; r.v = v; r.b = b; r.d = d;
        return r;
    endfunction

    // Packed {char, valid, busy, done}
    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got char=%h v=%b b=%b d=%b, want char=%h v=%b b=%b d=%b",
                     name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [10:0] e0, e2;
        int x0, x2, d0_at, d2_at, cyc;

        // Basic send, then a start during DONE that must be ignored
        vecs.push_back(mk(1, 0, 0, 1, "V", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "I", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "K", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "Y", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "A", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "T", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 5, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));
        // Backpressure on "K" with ignored starts mid-stream
        vecs.push_back(mk(1, 0, 0, 1, "V", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "I", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "K", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, "K", 1, 1, 0));
        vecs.push_back(mk(1, 3, 0, 0, "K", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, "K", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(1, 7, 0, 1, "Y", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "A", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "T", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));
        // Abort on "Y", abort beats start in IDLE, restart, abort on last char
        vecs.push_back(mk(1, 0, 0, 1, "V", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "I", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "K", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "Y", 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, "V", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "I", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "K", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "Y", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "A", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "T", 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, "H", 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0));

        // Reset state with no clock edge involved
        #1 rst = 1'b0;
        #2;
        chk("reset_dut0", {ch0, vld0, busy0, done0}, 11'h000);
        chk("reset_dut2", {ch2, vld2, busy2, done2}, 11'h000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st;
            rep   = vecs[i].rc;
            abort = vecs[i].ab;
            ready = vecs[i].rd;
            @(posedge clk);
            #1;
            e0 = {vecs[i].ch, vecs[i].v, vecs[i].b, vecs[i].d};
            chk($sformatf("vec%0d_dut0", i), {ch0, vld0, busy0, done0}, e0);
            chk($sformatf("vec%0d_dut2", i), {ch2, vld2, busy2, done2}, e0);
        end
        start = 1'b0; abort = 1'b0; ready = 1'b1; rep = 4'd0;

        // Repeat once: dut0 back-to-back, dut2 with a two-cycle gap
        start = 1'b1; rep = 4'd1;
        x0 = 0; x2 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0; rep = 4'd0;
            if (c <= 16)      e0 = {nm[(c - 1) % 8], 3'b110};
            else if (c == 17) e0 = {8'h00, 3'b001};
            else              e0 = 11'h000;
            if (c <= 8)       e2 = {nm[c - 1], 3'b110};
            else if (c <= 10) e2 = {8'h00, 3'b010};
            else if (c <= 18) e2 = {nm[c - 11], 3'b110};
            else if (c == 19) e2 = {8'h00, 3'b001};
            else              e2 = 11'h000;
            chk($sformatf("rep1_dut0_c%0d", c), {ch0, vld0, busy0, done0}, e0);
            chk($sformatf("rep1_dut2_c%0d", c), {ch2, vld2, busy2, done2}, e2);
            if (vld0 && ready) x0++;
            if (vld2 && ready) x2++;
        end
        chk_int("rep1_xfers_dut0", x0, 16);
        chk_int("rep1_xfers_dut2", x2, 16);

        // Maximum length: 16 names = 128 transfers
        start = 1'b1; rep = 4'd15;
        x0 = 0; x2 = 0; d0_at = -1; d2_at = -1; cyc = 0;
        while ((d0_at < 0 || d2_at < 0) && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0; rep = 4'd0;
            if (vld0) begin
                chk($sformatf("max_dut0_x%0d", x0), {ch0, 3'b000}, {nm[x0 % 8], 3'b000});
                x0++;
            end
            if (vld2) begin
                chk($sformatf("max_dut2_x%0d", x2), {ch2, 3'b000}, {nm[x2 % 8], 3'b000});
                x2++;
            end
            if (done0 && d0_at < 0) d0_at = cyc;
            if (done2 && d2_at < 0) d2_at = cyc;
        end
        chk_int("max_xfers_dut0", x0, 128);
        chk_int("max_xfers_dut2", x2, 128);
        chk_int("max_done_cycle_dut0", d0_at, 129);
        chk_int("max_done_cycle_dut2", d2_at, 159);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset between edges mid-stream
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_dut0", {ch0, vld0, busy0, done0}, {8'h4B, 3'b110});
        #3 rst = 1'b0;
        #1;
        chk("async_rst_dut0", {ch0, vld0, busy0, done0}, 11'h000);
        chk("async_rst_dut2", {ch2, vld2, busy2, done2}, 11'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_dut0", {ch0, vld0, busy0, done0}, 11'h000);
        chk("post_rst_idle_dut2", {ch2, vld2, busy2, done2}, 11'h000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_dut0", {ch0, vld0, busy0, done0}, {8'h56, 3'b110});
        chk("restart_dut2", {ch2, vld2, busy2, done2}, {8'h56, 3'b110});
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
